ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set, typematic, reset, etc.) from the host to a PS/2 keyboard. It requests to send, shifts the frame out on device-generated clock edges and checks the device's acknowledge bit. It shares the `ps2_clk`/`ps2_data` pads with the existing PS/2 receiver. It drives the open-drain pads only through active-high pull-low enables.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 2400: clock-low inhibit length in `clk` cycles (100 µs at 24 MHz); must be ≥ 2.
- `TIMEOUT_CYCLES`, default 360000: transaction watchdog in `clk` cycles (15 ms at 24 MHz), counted from release of the clock line.

Ports:
- `clk`  in  1: system clock (24 MHz).
- `reset`  in  1: asynchronous, active-high reset.
- `ps2_clk`  in  1: raw PS/2 clock pad level, asynchronous.
- `ps2_data`  in  1: raw PS/2 data pad level, asynchronous.
- `wr`  in  1: one-cycle write strobe; accepted only when `busy`=0.
- `d`  in  8: byte to send; captured on the accepted `wr`.
- `busy`  out  1: high from the cycle after an accepted `wr` until the return to IDLE.
- `done`  out  1: one-cycle pulse when the transfer is acknowledged by the device.
- `err`  out  1: one-cycle pulse on a missing ACK or a watchdog timeout.
- `ps2_clk_oe`  out  1: 1 pulls the PS/2 clock pad low; 0 releases it.
- `ps2_data_oe`  out  1: 1 pulls the PS/2 data pad low; 0 releases it.

## Operation
- Inputs pass through a 2-FF synchronizer.
  - `fall_ce` is a registered one-cycle strobe, high when the synchronized clock goes from 1 to 0.
- On an accepted `wr`, a 9-bit shift register loads {parity, `d`}.
  - Parity is odd: `~^d`.
  - The stop bit is sent as a released line (1).
- State machine states:
  - IDLE: both OEs 0, `busy`=0. An accepted `wr` moves to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1, `ps2_data_oe`=0 for exactly `INHIBIT_CYCLES` cycles, then REQ.
  - REQ: one cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit), then SHIFT. The watchdog is cleared here.
  - SHIFT: `ps2_clk_oe`=0, and `ps2_data_oe` holds the current bit.
    - On each `fall_ce`, the next bit is presented as `ps2_data_oe` = ~bit, in the order bit0…bit7, then parity.
    - The 10th `fall_ce` presents the stop bit (`ps2_data_oe`=0) and moves to ACK.
    - Bit counter is 4 bits, 0..9.
  - ACK: both OEs 0. On the next `fall_ce`, sample synchronized data.
    - Data 0: go to WAITIDLE with ACK ok.
    - Data 1: pulse `err` and go to IDLE.
  - WAITIDLE: wait until synchronized clock and data are both 1, then pulse `done` and go to IDLE.
- Watchdog:
  - A counter runs in SHIFT, ACK and WAITIDLE.
  - Reaching `TIMEOUT_CYCLES` releases both OEs, pulses `err` and returns to IDLE, all in the same cycle.
  - The watchdog is not active in INHIBIT.
- `wr` while `busy`=1 is ignored; `d` is not recaptured.
- `done` and `err` are never both high, and each pulses at most once per transfer.
- Integrators gate the receiver's captured data with `busy`. The ACK frame is not a keyboard byte.

## Timing
- Reset: asynchronous, immediate.
  - State IDLE; `busy`, `done`, `err`, `ps2_clk_oe` and `ps2_data_oe` all 0.
  - Counters and shift register cleared.
  - Reset mid-transfer releases both pads immediately and emits no `done`/`err`.
- `wr` high at cycle N:
  - `busy`=1 and `ps2_clk_oe`=1 from N+1.
  - REQ occupies cycle N+1+`INHIBIT_CYCLES`.
  - `ps2_clk_oe` falls at N+2+`INHIBIT_CYCLES`.
- Pin-edge-to-response latency: a falling edge on the `ps2_clk` pin is seen at sync stage 2 after 2 cycles, `fall_ce` fires 1 cycle later, and `ps2_data_oe` updates on the following edge.
  - Worst case is 4 `clk` cycles, far inside the device's ≥ 5 µs low phase.
- The `done`/`err` pulse coincides with the first IDLE cycle. `busy` falls in the same cycle.
- A `wr` asserted in the same cycle that `done` pulses (busy=0) is accepted.

## Test plan
- Send 0xED against a device model that clocks at 12.5 kHz and ACKs.
  - Required: inhibit ≥ 100 µs; data bits sampled on rising edges are 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - Required: one `done` pulse, no `err`, `busy` low afterwards.
- Send 0x01, 0x00 and 0xFF back-to-back, each `wr` issued on its `done` cycle.
  - Required parity: 0, 1, 1 respectively; three `done` pulses.
- Device holds data high during the ACK clock.
  - Required: `err` pulses once, no `done`, both OEs are 0 in the same cycle.
- Device never clocks after REQ.
  - Required: `err` exactly `TIMEOUT_CYCLES` cycles after entering SHIFT, OEs released, `busy` falls.
- `wr` with 0x55 during SHIFT of 0xF4.
  - Required: the frame on the wire is 0xF4 only, and only one `done` occurs.
- Assert `reset` asynchronously (mid-cycle) during bit 4 of SHIFT.
  - Required: OEs go to 0 before the next `clk` edge, no `done`/`err`.
  - Required: a subsequent `wr` of 0xFF completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, shifts
// one byte plus odd parity on device clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2400,
  parameter int unsigned TIMEOUT_CYCLES = 360000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       wr,
  input  logic [7:0] d,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAITIDLE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev, fall_ce;
  logic [8:0]    sr, sr_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          bit_oe, bit_oe_nxt;
  logic          done_nxt, err_nxt;
  logic          timeout;

  // Synchronizers idle high so that leaving reset never fakes a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      fall_ce   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
      fall_ce   <= clk_prev & ~clk_sync[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      tmr    <= '0;
      bit_oe <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      tmr    <= tmr_nxt;
      bit_oe <= bit_oe_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  assign timeout = (tmr == TO_LAST);

  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    cnt_nxt    = cnt;
    tmr_nxt    = tmr;
    bit_oe_nxt = bit_oe;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (wr) begin
          state_nxt  = INHIBIT;
          sr_nxt     = {~^d, d};
          cnt_nxt    = '0;
          tmr_nxt    = '0;
          bit_oe_nxt = 1'b0;
        end
      end
      INHIBIT: begin
        if (tmr == INH_LAST) begin
          state_nxt = REQ;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      REQ: begin
        state_nxt  = SHIFT;
        tmr_nxt    = '0;
        cnt_nxt    = '0;
        bit_oe_nxt = 1'b1;
      end
      SHIFT, ACK, WAITIDLE: begin
        tmr_nxt = tmr + TW'(1);
        if (timeout) begin
          state_nxt  = IDLE;
          bit_oe_nxt = 1'b0;
          err_nxt    = 1'b1;
        end else if (state == SHIFT) begin
          // cnt 0..8 present data/parity bits, cnt 9 presents the released stop bit.
          if (fall_ce) begin
            if (cnt == 4'd9) begin
              bit_oe_nxt = 1'b0;
              state_nxt  = ACK;
            end else begin
              bit_oe_nxt = ~sr[0];
              sr_nxt     = {1'b0, sr[8:1]};
              cnt_nxt    = cnt + 4'd1;
            end
          end
        end else if (state == ACK) begin
          if (fall_ce) begin
            if (!data_sync[1]) begin
              state_nxt = WAITIDLE;
            end else begin
              state_nxt = IDLE;
              err_nxt   = 1'b1;
            end
          end
        end else begin
          if (clk_sync[1] && data_sync[1]) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
  assign ps2_data_oe = (state == REQ) || ((state == SHIFT) && bit_oe);

endmodule
